// File: rtl/miner_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// miner_pkg : register map, control/status bit positions and FSM encoding
// Rev 1.0   : initial release
// ---------------------------------------------------------------------------
package miner_pkg;

  localparam logic [7:0] OFF_CTRL    = 8'h00;
  localparam logic [7:0] OFF_STATUS  = 8'h04;
  localparam logic [7:0] OFF_MID0    = 8'h08;
  localparam logic [7:0] OFF_TAIL0   = 8'h28;
  localparam logic [7:0] OFF_NSTART  = 8'h34;
  localparam logic [7:0] OFF_NEND    = 8'h38;
  localparam logic [7:0] OFF_RESULT  = 8'h3C;

  localparam int CTRL_START  = 0;
  localparam int CTRL_ABORT  = 1;
  localparam int CTRL_IRQ_EN = 2;
  localparam int STAT_FULL   = 8;
  localparam int STAT_OVF    = 9;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_PENDING = 2'd1;
  localparam logic [1:0] ST_RUNNING = 2'd2;

  // MIDSTATE[0..7], TAIL[0..2], NONCE_START, NONCE_END
  localparam int JOB_WORDS = 13;

  function automatic logic [31:0] byte_merge(input logic [31:0] old_val,
                                             input logic [31:0] new_val,
                                             input logic [3:0]  sel);
    logic [31:0] merged;
    for (int b = 0; b < 4; b++) begin
      merged[b*8 +: 8] = sel[b] ? new_val[b*8 +: 8] : old_val[b*8 +: 8];
    end
    return merged;
  endfunction

endpackage
`default_nettype wire

// File: rtl/miner_result_fifo.sv
`default_nettype none
// ---------------------------------------------------------------------------
// miner_result_fifo : synchronous FIFO for winning nonces, first-word-fall-through head
// Rev 1.0           : initial release
// ---------------------------------------------------------------------------
module miner_result_fifo #(
  parameter int DEPTH = 4,
  parameter int CW    = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          i_rst,
  input  logic          i_push,
  input  logic [31:0]   i_data,
  input  logic          i_pop,
  output logic [31:0]   o_head,
  output logic          o_full,
  output logic          o_empty,
  output logic [CW-1:0] o_count
);
  import miner_pkg::*;

  localparam int AW = $clog2(DEPTH);

  logic [31:0]   r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  logic          w_do_pop;
  logic          w_do_push;

  assign o_full    = (r_count == CW'(DEPTH));
  assign o_empty   = (r_count == '0);
  assign o_count   = r_count;
  assign o_head    = r_mem[r_rd_ptr];
  // A pop frees a slot in the same cycle, so a full FIFO still accepts a push alongside it
  assign w_do_pop  = i_pop & ~o_empty;
  assign w_do_push = i_push & (~o_full | w_do_pop);

  always_ff @(posedge clk) begin
    if (i_rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) begin
        r_mem[r_wr_ptr] <= i_data;
        r_wr_ptr        <= r_wr_ptr + 1'b1;
      end
      if (w_do_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/miner_wb_regs.sv
`default_nettype none
// ---------------------------------------------------------------------------
// miner_wb_regs : Wishbone register front-end for the miner core (job capture, result FIFO)
// Rev 1.0       : initial release
// ---------------------------------------------------------------------------
module miner_wb_regs #(
  parameter logic [31:0] BASE_ADDR  = 32'h3000_0000,
  parameter int          FIFO_DEPTH = 4
) (
  input  logic         clk,
  input  logic         i_wb_rst,
  input  logic         i_wb_cycle,
  input  logic         i_wb_strobe,
  input  logic         i_wb_we,
  input  logic [3:0]   i_wb_sel,
  input  logic [31:0]  i_wb_addr,
  input  logic [31:0]  i_wb_wdata,
  output logic         o_wb_ack,
  output logic [31:0]  o_wb_rdata,
  output logic         o_job_valid,
  input  logic         i_job_ready,
  output logic [255:0] o_job_midstate,
  output logic [95:0]  o_job_tail,
  output logic [31:0]  o_job_nonce_start,
  output logic [31:0]  o_job_nonce_end,
  output logic         o_job_abort,
  input  logic         i_core_done,
  input  logic         i_res_valid,
  input  logic [31:0]  i_res_nonce,
  output logic         o_irq
);
  import miner_pkg::*;

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic [31:0]   r_job [JOB_WORDS];
  logic [1:0]    r_state;
  logic          r_ack;
  logic [31:0]   r_rdata;
  logic          r_abort;
  logic          r_irq_en;
  logic          r_ovf;

  logic          w_req, w_mapped, w_wr, w_rd;
  logic [7:0]    w_off;
  logic [3:0]    w_word;
  logic [3:0]    w_cfg_idx;
  logic          w_is_cfg, w_cfg_wr, w_ctrl_wr, w_start, w_abort, w_ovf_clr;
  logic          w_pop, w_full, w_empty;
  logic [31:0]   w_head, w_rdata;
  logic [CW-1:0] w_count;

  assign w_req     = i_wb_cycle & i_wb_strobe & ~r_ack;
  assign w_off     = i_wb_addr[7:0];
  assign w_mapped  = (i_wb_addr[31:8] == BASE_ADDR[31:8]) && (w_off[1:0] == 2'b00) &&
                     (w_off <= OFF_RESULT);
  assign w_word    = w_off[5:2];
  assign w_cfg_idx = w_word - 4'd2;
  assign w_is_cfg  = (w_word >= 4'd2) && (w_word <= 4'd14);
  assign w_wr      = w_req & i_wb_we & w_mapped;
  assign w_rd      = w_req & ~i_wb_we & w_mapped;
  // Job fields are frozen outside IDLE so the core never sees them change mid-job
  assign w_cfg_wr  = w_wr & w_is_cfg & (r_state == ST_IDLE);
  assign w_ctrl_wr = w_wr & (w_word == 4'd0) & i_wb_sel[0];
  assign w_start   = w_ctrl_wr & i_wb_wdata[CTRL_START];
  assign w_abort   = w_ctrl_wr & i_wb_wdata[CTRL_ABORT];
  assign w_ovf_clr = w_wr & (w_word == 4'd1) & i_wb_sel[1] & i_wb_wdata[STAT_OVF];
  assign w_pop     = w_rd & (w_word == 4'd15) & ~w_empty;

  miner_result_fifo #(.DEPTH(FIFO_DEPTH), .CW(CW)) u_fifo (
    .clk     (clk),
    .i_rst   (i_wb_rst),
    .i_push  (i_res_valid),
    .i_data  (i_res_nonce),
    .i_pop   (w_pop),
    .o_head  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (w_count)
  );

  always_comb begin
    w_rdata = '0;
    if (w_mapped) begin
      if (w_word == 4'd0) begin
        w_rdata[CTRL_IRQ_EN] = r_irq_en;
        w_rdata[1]           = (r_state == ST_RUNNING);
        w_rdata[0]           = (r_state == ST_PENDING);
      end else if (w_word == 4'd1) begin
        w_rdata[CW-1:0]  = w_count;
        w_rdata[STAT_FULL] = w_full;
        w_rdata[STAT_OVF]  = r_ovf;
      end else if (w_is_cfg) begin
        w_rdata = r_job[w_cfg_idx];
      end else begin
        w_rdata = w_empty ? 32'hFFFF_FFFF : w_head;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (i_wb_rst) begin
      r_ack    <= 1'b0;
      r_rdata  <= '0;
      r_irq_en <= 1'b0;
      r_ovf    <= 1'b0;
      for (int i = 0; i < JOB_WORDS; i++) r_job[i] <= '0;
    end else begin
      r_ack   <= w_req;
      r_rdata <= w_rd ? w_rdata : 32'h0;
      if (w_ctrl_wr) r_irq_en <= i_wb_wdata[CTRL_IRQ_EN];
      if (i_res_valid && w_full && !w_pop) r_ovf <= 1'b1;
      else if (w_ovf_clr)                  r_ovf <= 1'b0;
      if (w_cfg_wr) r_job[w_cfg_idx] <= byte_merge(r_job[w_cfg_idx], i_wb_wdata, i_wb_sel);
    end
  end

  always_ff @(posedge clk) begin
    if (i_wb_rst) begin
      r_state <= ST_IDLE;
      r_abort <= 1'b0;
    end else begin
      r_abort <= 1'b0;
      if (w_abort) begin
        r_abort <= (r_state != ST_IDLE);
        r_state <= ST_IDLE;
      end else begin
        case (r_state)
          ST_IDLE:    if (w_start)     r_state <= ST_PENDING;
          ST_PENDING: if (i_job_ready) r_state <= ST_RUNNING;
          ST_RUNNING: if (i_core_done) r_state <= ST_IDLE;
          default:                     r_state <= ST_IDLE;
        endcase
      end
    end
  end

  for (genvar gi = 0; gi < 8; gi++) begin : g_mid
    assign o_job_midstate[gi*32 +: 32] = r_job[gi];
  end
  for (genvar gi = 0; gi < 3; gi++) begin : g_tail
    assign o_job_tail[gi*32 +: 32] = r_job[8+gi];
  end

  assign o_job_nonce_start = r_job[11];
  assign o_job_nonce_end   = r_job[12];
  assign o_job_valid       = (r_state == ST_PENDING);
  assign o_job_abort       = r_abort;
  assign o_wb_ack          = r_ack;
  assign o_wb_rdata        = r_rdata;
  assign o_irq             = r_irq_en & ~w_empty;

endmodule
`default_nettype wire

// File: tb/tb_miner_wb_regs.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_miner_wb_regs : table-driven register checks plus scoreboarded Wishbone reads
// Rev 1.0          : initial release
// ---------------------------------------------------------------------------
module tb_miner_wb_regs;

  localparam logic [31:0] BASE = 32'h3000_0000;

  logic         clk = 1'b0;
  logic         i_wb_rst = 1'b1;
  logic         i_wb_cycle = 1'b0, i_wb_strobe = 1'b0, i_wb_we = 1'b0;
  logic [3:0]   i_wb_sel = 4'h0;
  logic [31:0]  i_wb_addr = '0, i_wb_wdata = '0;
  logic         o_wb_ack;
  logic [31:0]  o_wb_rdata;
  logic         o_job_valid, i_job_ready = 1'b0;
  logic [255:0] o_job_midstate;
  logic [95:0]  o_job_tail;
  logic [31:0]  o_job_nonce_start, o_job_nonce_end;
  logic         o_job_abort;
  logic         i_core_done = 1'b0, i_res_valid = 1'b0;
  logic [31:0]  i_res_nonce = '0;
  logic         o_irq;

  always #5 clk = ~clk;

  miner_wb_regs #(.BASE_ADDR(BASE), .FIFO_DEPTH(4)) dut (
    .clk(clk), .i_wb_rst(i_wb_rst), .i_wb_cycle(i_wb_cycle), .i_wb_strobe(i_wb_strobe),
    .i_wb_we(i_wb_we), .i_wb_sel(i_wb_sel), .i_wb_addr(i_wb_addr), .i_wb_wdata(i_wb_wdata),
    .o_wb_ack(o_wb_ack), .o_wb_rdata(o_wb_rdata), .o_job_valid(o_job_valid),
    .i_job_ready(i_job_ready), .o_job_midstate(o_job_midstate), .o_job_tail(o_job_tail),
    .o_job_nonce_start(o_job_nonce_start), .o_job_nonce_end(o_job_nonce_end),
    .o_job_abort(o_job_abort), .i_core_done(i_core_done), .i_res_valid(i_res_valid),
    .i_res_nonce(i_res_nonce), .o_irq(o_irq)
  );

  typedef struct { string name; logic [31:0] exp; bit chk; } exp_t;
  typedef struct { string name; bit we; logic [3:0] sel; logic [7:0] off;
                   logic [31:0] wdata; logic [31:0] exp; } vec_t;

  exp_t sb[$];
  exp_t mon_e;
  vec_t vecs[$];
  int   n_checks = 0;
  int   n_fail = 0;
  int   last_lat = 0;
  int   acks;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Scoreboard consumer: every ack pops one expectation in issue order
  always @(negedge clk) begin
    if (o_wb_ack) begin
      if (sb.size() == 0) begin
        n_checks++; n_fail++;
        $display("FAIL unexpected_ack: got ack with rdata %h expected no ack", o_wb_rdata);
      end else begin
        mon_e = sb.pop_front();
        if (mon_e.chk) check(mon_e.name, o_wb_rdata, mon_e.exp);
      end
    end else if (o_wb_rdata !== 32'h0) begin
      n_checks++; n_fail++;
      $display("FAIL rdata_idle: got %h expected 00000000", o_wb_rdata);
    end
  end

  task automatic wb_xfer(input bit we, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [3:0] sel, input logic [31:0] exp, input bit chk,
                         input string name, input bit res_pulse, input logic [31:0] res_n);
    @(negedge clk);
    while (o_wb_ack) @(negedge clk);
    i_wb_cycle = 1'b1; i_wb_strobe = 1'b1; i_wb_we = we;
    i_wb_sel = sel; i_wb_addr = addr; i_wb_wdata = wdata;
    if (res_pulse) begin i_res_valid = 1'b1; i_res_nonce = res_n; end
    sb.push_back('{name, exp, chk});
    last_lat = 0;
    for (int k = 1; k <= 5; k++) begin
      @(posedge clk); #1;
      i_res_valid = 1'b0;
      if (o_wb_ack) begin last_lat = k; break; end
    end
    i_wb_cycle = 1'b0; i_wb_strobe = 1'b0; i_wb_we = 1'b0;
    if (last_lat == 0) begin
      n_checks++; n_fail++;
      $display("FAIL %s_timeout: got no ack expected ack within 5 cycles", name);
      void'(sb.pop_back());
    end
  endtask

  task automatic wb_wr(input logic [7:0] off, input logic [31:0] d);
    wb_xfer(1'b1, BASE | 32'(off), d, 4'hF, 32'h0, 1'b0, "wr", 1'b0, 32'h0);
  endtask

  task automatic wb_rd(input logic [7:0] off, input logic [31:0] exp, input string name);
    wb_xfer(1'b0, BASE | 32'(off), 32'h0, 4'h0, exp, 1'b1, name, 1'b0, 32'h0);
  endtask

  task automatic push_res(input logic [31:0] n);
    @(negedge clk);
    i_res_valid = 1'b1; i_res_nonce = n;
    @(negedge clk);
    i_res_valid = 1'b0;
  endtask

  task automatic pulse_ready();
    @(negedge clk); i_job_ready = 1'b1;
    @(posedge clk); #1; i_job_ready = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish expected finish before time limit");
    $fatal(1);
  end

  initial begin
    repeat (3) @(posedge clk);
    #1 i_wb_rst = 1'b0;
    check("rst_ack", 32'(o_wb_ack), 0);
    check("rst_job_valid", 32'(o_job_valid), 0);
    check("rst_job_abort", 32'(o_job_abort), 0);
    check("rst_irq", 32'(o_irq), 0);

    for (int o = 0; o <= 'h3C; o += 4)
      vecs.push_back('{$sformatf("rst_rd_%02h", o), 1'b0, 4'h0, 8'(o), 32'h0,
                       (o == 'h3C) ? 32'hFFFF_FFFF : 32'h0});
    vecs.push_back('{"rd_unmapped_40", 1'b0, 4'h0, 8'h40, 32'h0, 32'h0});
    vecs.push_back('{"wr_mid0_lo",     1'b1, 4'h3, 8'h08, 32'h6A09_E667, 32'h0});
    vecs.push_back('{"rd_mid0_lo",     1'b0, 4'h0, 8'h08, 32'h0, 32'h0000_E667});
    vecs.push_back('{"wr_mid1_hi",     1'b1, 4'hC, 8'h0C, 32'h1122_3344, 32'h0});
    vecs.push_back('{"rd_mid1_hi",     1'b0, 4'h0, 8'h0C, 32'h0, 32'h1122_0000});
    vecs.push_back('{"wr_unmapped_44", 1'b1, 4'hF, 8'h44, 32'hFFFF_FFFF, 32'h0});
    vecs.push_back('{"rd_unmapped_44", 1'b0, 4'h0, 8'h44, 32'h0, 32'h0});

    foreach (vecs[i]) begin
      wb_xfer(vecs[i].we, BASE | 32'(vecs[i].off), vecs[i].wdata, vecs[i].sel,
              vecs[i].exp, !vecs[i].we, vecs[i].name, 1'b0, 32'h0);
      if (i == 0) check("ack_latency", 32'(last_lat), 1);
    end
    check("job_mid0_port", o_job_midstate[31:0], 32'h0000_E667);

    wb_xfer(1'b1, BASE + 32'h108, 32'hFFFF_FFFF, 4'hF, 0, 1'b0, "wr_oob", 1'b0, 0);
    wb_xfer(1'b0, 32'h3100_0008, 0, 4'h0, 32'h0, 1'b1, "rd_oob", 1'b0, 0);
    wb_rd(8'h08, 32'h0000_E667, "mid0_after_oob");

    // Held strobe: ack toggles on alternate cycles
    @(negedge clk);
    while (o_wb_ack) @(negedge clk);
    sb.push_back('{"b2b_ctrl0", 32'h0, 1'b1});
    sb.push_back('{"b2b_ctrl1", 32'h0, 1'b1});
    i_wb_cycle = 1'b1; i_wb_strobe = 1'b1; i_wb_we = 1'b0; i_wb_addr = BASE;
    acks = 0;
    repeat (4) begin @(posedge clk); #1; if (o_wb_ack) acks++; end
    i_wb_cycle = 1'b0; i_wb_strobe = 1'b0;
    check("b2b_ack_count", 32'(acks), 2);

    for (int i = 0; i < 13; i++) wb_wr(8'(8 + 4*i), 32'hC0DE_0000 | 32'(i));
    check("job_mid7", o_job_midstate[255:224], 32'hC0DE_0007);
    check("job_tail2", o_job_tail[95:64], 32'hC0DE_000A);
    check("job_nstart", o_job_nonce_start, 32'hC0DE_000B);
    check("job_nend", o_job_nonce_end, 32'hC0DE_000C);
    check("idle_job_valid", 32'(o_job_valid), 0);

    wb_wr(8'h00, 32'h1);
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      check($sformatf("pending_valid_%0d", c), 32'(o_job_valid), 1);
    end
    wb_rd(8'h00, 32'h1, "ctrl_pending");
    pulse_ready();
    check("running_valid", 32'(o_job_valid), 0);
    wb_rd(8'h00, 32'h2, "ctrl_running");
    wb_wr(8'h08, 32'h1234_5678);
    wb_rd(8'h08, 32'hC0DE_0000, "mid0_locked");
    wb_wr(8'h00, 32'h1);
    wb_rd(8'h00, 32'h2, "start_ignored");
    @(negedge clk); i_core_done = 1'b1;
    @(negedge clk); i_core_done = 1'b0;
    wb_rd(8'h00, 32'h0, "ctrl_done");

    wb_wr(8'h00, 32'h1);
    wb_rd(8'h00, 32'h1, "ctrl_pending2");
    wb_wr(8'h00, 32'h2);
    check("abort_pend_pulse", 32'(o_job_abort), 1);
    @(posedge clk); #1;
    check("abort_pulse_end", 32'(o_job_abort), 0);
    wb_rd(8'h00, 32'h0, "ctrl_after_abort");

    wb_wr(8'h00, 32'h1);
    pulse_ready();
    wb_rd(8'h00, 32'h2, "ctrl_running2");
    wb_wr(8'h00, 32'h2);
    check("abort_run_pulse", 32'(o_job_abort), 1);
    wb_rd(8'h00, 32'h0, "ctrl_after_abort2");

    wb_wr(8'h00, 32'h2);
    check("abort_idle_nopulse", 32'(o_job_abort), 0);
    wb_wr(8'h00, 32'h3);
    check("start_abort_nopulse", 32'(o_job_abort), 0);
    wb_rd(8'h00, 32'h0, "ctrl_start_abort");
    wb_wr(8'h00, 32'h4);
    wb_rd(8'h00, 32'h4, "ctrl_irq_en");
    check("irq_empty", 32'(o_irq), 0);

    for (int i = 0; i < 5; i++) push_res(32'hA0 + 32'(i));
    check("irq_nonempty", 32'(o_irq), 1);
    wb_rd(8'h04, 32'h304, "status_ovf_full");
    for (int i = 0; i < 4; i++) wb_rd(8'h3C, 32'hA0 + 32'(i), $sformatf("res_%0d", i));
    wb_rd(8'h3C, 32'hFFFF_FFFF, "res_empty");
    check("irq_drained", 32'(o_irq), 0);
    wb_rd(8'h04, 32'h200, "status_ovf_sticky");
    wb_wr(8'h04, 32'h200);
    wb_rd(8'h04, 32'h0, "status_w1c");

    for (int i = 0; i < 4; i++) push_res(32'hB0 + 32'(i));
    wb_rd(8'h04, 32'h104, "status_full");
    wb_xfer(1'b0, BASE | 32'h3C, 0, 4'h0, 32'hB0, 1'b1, "res_pop_push", 1'b1, 32'hDEAD_BEEF);
    wb_rd(8'h04, 32'h104, "status_pop_push");
    for (int i = 1; i < 4; i++) wb_rd(8'h3C, 32'hB0 + 32'(i), $sformatf("resb_%0d", i));
    wb_rd(8'h3C, 32'hDEAD_BEEF, "res_deadbeef");
    wb_rd(8'h3C, 32'hFFFF_FFFF, "res_empty2");

    push_res(32'hC1);
    wb_wr(8'h00, 32'h2);
    wb_rd(8'h3C, 32'hC1, "res_after_abort");

    // Reset arriving with a request outstanding must not produce an ack
    push_res(32'hE1);
    @(negedge clk);
    while (o_wb_ack) @(negedge clk);
    i_wb_cycle = 1'b1; i_wb_strobe = 1'b1; i_wb_we = 1'b0; i_wb_addr = BASE;
    i_wb_rst = 1'b1;
    @(posedge clk); #1;
    check("rst_drops_ack", 32'(o_wb_ack), 0);
    i_wb_cycle = 1'b0; i_wb_strobe = 1'b0;
    @(posedge clk); #1;
    i_wb_rst = 1'b0;
    check("rst2_irq", 32'(o_irq), 0);
    wb_rd(8'h04, 32'h0, "rst2_status");
    wb_rd(8'h00, 32'h0, "rst2_ctrl");
    wb_rd(8'h3C, 32'hFFFF_FFFF, "rst2_result");
    wb_rd(8'h08, 32'h0, "rst2_mid0");

    repeat (3) @(posedge clk);
    #1 check("sb_drain", 32'(sb.size()), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
